// File: rtl/screen_seq_pkg.sv
// -----------------------------------------------------------------------------
// screen_seq_pkg
// Shared constants for the VGA game screen sequencer:
//   - screen/state codes TITLE..WIN (also the value driven on screen_sel)
//   - RGB bus width and the channel slice positions of {r[2:0],g[2:0],b[1:0]}
//   - rgb_fade(): per-channel logical right shift used by the fade-in build
// -----------------------------------------------------------------------------
package screen_seq_pkg;

  localparam int RGB_W = 8;

  // State codes, 3 bits wide so they can be driven straight onto screen_sel.
  localparam logic [2:0] TITLE = 3'd0;
  localparam logic [2:0] BLANK = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] LOSE  = 3'd3;
  localparam logic [2:0] WIN   = 3'd4;

  // Channel slice positions inside an RGB_W pixel.
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  // Shift every channel right by s. Each slice is self-determined, so a
  // shift of 3 clears the 2-bit blue channel as well as red and green.
  function automatic logic [RGB_W-1:0] rgb_fade(input logic [RGB_W-1:0] px,
                                                input logic [1:0]       s);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = px[R_HI:R_LO] >> s;
    g = px[G_HI:G_LO] >> s;
    b = px[B_HI:B_LO] >> s;
    return {r, g, b};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Two-flop synchronizer for a raw asynchronous push-button followed by a
// rising-edge detector. Reusable for any button in the design.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous, active-high reset (clears both synchronizer
//              stages and the edge history)
//   btn    in  raw button level, asynchronous to clk
//   pulse  out one-clk pulse on each synchronized rising edge of btn
// -----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync;
  logic       btn_d;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours (a real shift chain).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      btn_d <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      btn_d <= sync[1];
    end
  end

  assign pulse = sync[1] & ~btn_d;

endmodule

// File: rtl/screen_seq_ctrl.sv
// -----------------------------------------------------------------------------
// screen_seq_ctrl
// Top-level screen sequencer for the VGA game. FSM TITLE -> PLAY -> LOSE/WIN
// -> TITLE with BLANK_FRAMES black frames (BLANK state) between screens. State
// changes only on the frame tick (falling edge of the active-low vs). The four
// screen generators' pixels are muxed onto a registered rgb bus.
//
// Build option: define SCREEN_SEQ_FADE_EN to fade the destination screen in
// during the last frames of BLANK; by default BLANK drives constant black.
//
// Parameters:
//   BLANK_FRAMES   black frames between screens (1..255)
//   HOLD_FRAMES    frames on LOSE/WIN before a start press is accepted
//   TIMEOUT_FRAMES frames on LOSE/WIN before auto return to TITLE (0 = never)
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   vs            active-low vertical sync, synchronous to clk
//   start_btn     raw asynchronous start button
//   player_dead   game lost (level)      level_done  game won (level)
//   title_rgb, play_rgb, lose_rgb, win_rgb   screen generator pixels
//   rgb           registered muxed pixel (1 clk latency)
//   screen_sel    current state code
//   game_en       high only in PLAY
//   game_rst      one-clk pulse on the clk that takes BLANK -> PLAY
//   frame_cnt     frames elapsed in current state, saturating at 255
// -----------------------------------------------------------------------------
module screen_seq_ctrl
  import screen_seq_pkg::*;
#(
  parameter int unsigned BLANK_FRAMES   = 8,
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned TIMEOUT_FRAMES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             start_btn,
  input  logic             player_dead,
  input  logic             level_done,
  input  logic [RGB_W-1:0] title_rgb,
  input  logic [RGB_W-1:0] play_rgb,
  input  logic [RGB_W-1:0] lose_rgb,
  input  logic [RGB_W-1:0] win_rgb,
  output logic [RGB_W-1:0] rgb,
  output logic [2:0]       screen_sel,
  output logic             game_en,
  output logic             game_rst,
  output logic [7:0]       frame_cnt
);

  localparam logic [7:0] BLANK_LAST  = 8'(BLANK_FRAMES - 1);
  localparam logic [7:0] HOLD_CNT    = 8'(HOLD_FRAMES);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_FRAMES);
  localparam bit         TIMEOUT_ON  = (TIMEOUT_FRAMES != 0);

  logic [2:0]       state;
  logic [2:0]       target;
  logic [2:0]       state_nx;
  logic [2:0]       target_nx;
  logic             vs_d;
  logic             tick;
  logic             start_pulse;
  logic             start_pend;
  logic             dead_pend;
  logic             win_pend;
  logic             start_ok;
  logic [RGB_W-1:0] rgb_nx;

  // ---------------------------------------------------------------- inputs
  btn_sync_edge u_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .pulse (start_pulse)
  );

  // vs_d resets low so the idle-high vs cannot fake a tick after reset.
  assign tick     = vs_d & ~vs;
  assign start_ok = (state == TITLE) || (state == LOSE) || (state == WIN);

  // ---------------------------------------------------------- next state
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    if (tick) begin
      case (state)
        TITLE: begin
          if (start_pend) begin
            state_nx  = BLANK;
            target_nx = PLAY;
          end
        end
        BLANK: begin
          if (frame_cnt == BLANK_LAST) state_nx = target;
        end
        PLAY: begin
          // Loss outranks a simultaneous win.
          if (dead_pend) begin
            state_nx  = BLANK;
            target_nx = LOSE;
          end else if (win_pend) begin
            state_nx  = BLANK;
            target_nx = WIN;
          end
        end
        LOSE, WIN: begin
          // An early press simply falls through; its flag clears on this tick.
          if (start_pend && (frame_cnt >= HOLD_CNT)) begin
            state_nx  = BLANK;
            target_nx = TITLE;
          end else if (TIMEOUT_ON && (frame_cnt == TIMEOUT_CNT)) begin
            state_nx  = BLANK;
            target_nx = TITLE;
          end
        end
        default: begin
          state_nx  = TITLE;
          target_nx = TITLE;
        end
      endcase
    end
  end

  // ------------------------------------------------- state, counter, flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TITLE;
      target     <= TITLE;
      vs_d       <= 1'b0;
      frame_cnt  <= 8'd0;
      start_pend <= 1'b0;
      dead_pend  <= 1'b0;
      win_pend   <= 1'b0;
    end else begin
      vs_d   <= vs;
      state  <= state_nx;
      target <= target_nx;
      if (tick) begin
        // Flags live for one frame only, consumed or not.
        start_pend <= 1'b0;
        dead_pend  <= 1'b0;
        win_pend   <= 1'b0;
        if (state_nx != state)       frame_cnt <= 8'd0;
        else if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
      end else begin
        if (start_pulse && start_ok)          start_pend <= 1'b1;
        if (player_dead && (state == PLAY))   dead_pend  <= 1'b1;
        if (level_done  && (state == PLAY))   win_pend   <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ pixel mux
`ifdef SCREEN_SEQ_FADE_EN
  logic [RGB_W-1:0] target_px;
  logic [7:0]       frames_left;
  logic [1:0]       fade_s;

  always_comb begin
    case (target)
      PLAY:    target_px = play_rgb;
      LOSE:    target_px = lose_rgb;
      WIN:     target_px = win_rgb;
      default: target_px = title_rgb;
    endcase
  end

  // frame_cnt never exceeds BLANK_LAST while in BLANK, so this cannot wrap.
  assign frames_left = BLANK_LAST - frame_cnt;
  assign fade_s      = (frames_left >= 8'd3) ? 2'd3 : frames_left[1:0];
`endif

  always_comb begin
    rgb_nx = '0;
    case (state)
      TITLE: rgb_nx = title_rgb;
      PLAY:  rgb_nx = play_rgb;
      LOSE:  rgb_nx = lose_rgb;
      WIN:   rgb_nx = win_rgb;
`ifdef SCREEN_SEQ_FADE_EN
      BLANK: rgb_nx = rgb_fade(target_px, fade_s);
`else
      BLANK: rgb_nx = '0;
`endif
      default: rgb_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb <= '0;
    else     rgb <= rgb_nx;
  end

  // -------------------------------------------------------------- outputs
  assign screen_sel = state;
  assign game_en    = (state == PLAY);
  assign game_rst   = tick && (state == BLANK) && (state_nx == PLAY);

endmodule

// File: tb/tb_screen_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_screen_seq_ctrl
// Directed self-checking bench for screen_seq_ctrl. Two instances share all
// inputs: dut uses default parameters, dut_nt has TIMEOUT_FRAMES=0.
// A frame is 16 clks; vs is low on frame clks 13..14, so each frame ends with
// exactly one tick and state/rgb have settled by the end of the frame task.
// -----------------------------------------------------------------------------
module tb_screen_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs;
  logic       start_btn;
  logic       player_dead;
  logic       level_done;
  logic [7:0] title_rgb;
  logic [7:0] play_rgb;
  logic [7:0] lose_rgb;
  logic [7:0] win_rgb;

  logic [7:0] rgb;
  logic [2:0] screen_sel;
  logic       game_en;
  logic       game_rst;
  logic [7:0] frame_cnt;

  logic [7:0] rgb_nt;
  logic [2:0] screen_sel_nt;
  logic       game_en_nt;
  logic       game_rst_nt;
  logic [7:0] frame_cnt_nt;

  int n_cmp = 0;
  int n_bad = 0;
  int rst_hi_cnt;

  always #5 clk = ~clk;

  screen_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .vs          (vs),
    .start_btn   (start_btn),
    .player_dead (player_dead),
    .level_done  (level_done),
    .title_rgb   (title_rgb),
    .play_rgb    (play_rgb),
    .lose_rgb    (lose_rgb),
    .win_rgb     (win_rgb),
    .rgb         (rgb),
    .screen_sel  (screen_sel),
    .game_en     (game_en),
    .game_rst    (game_rst),
    .frame_cnt   (frame_cnt)
  );

  screen_seq_ctrl #(.TIMEOUT_FRAMES(0)) dut_nt (
    .clk         (clk),
    .rst         (rst),
    .vs          (vs),
    .start_btn   (start_btn),
    .player_dead (player_dead),
    .level_done  (level_done),
    .title_rgb   (title_rgb),
    .play_rgb    (play_rgb),
    .lose_rgb    (lose_rgb),
    .win_rgb     (win_rgb),
    .rgb         (rgb_nt),
    .screen_sel  (screen_sel_nt),
    .game_en     (game_en_nt),
    .game_rst    (game_rst_nt),
    .frame_cnt   (frame_cnt_nt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame; optional start press (clks 2..5) and one-clk game events (clk 3).
  task automatic frame(input bit press, input bit dead, input bit done);
    rst_hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vs          = !((i == 13) || (i == 14));
      start_btn   = press && (i >= 2) && (i <= 5);
      player_dead = dead && (i == 3);
      level_done  = done && (i == 3);
      #1;
      if (game_rst) rst_hi_cnt++;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    vs          = 1'b1;
    start_btn   = 1'b0;
    player_dead = 1'b0;
    level_done  = 1'b0;
    title_rgb   = 8'hA5;
    play_rgb    = 8'h3C;
    lose_rgb    = 8'hC3;
    win_rgb     = 8'h5A;

    // 1. Reset state, then TITLE pixel one clk after release.
    repeat (2) @(negedge clk);
    #1;
    check("rst_state",    32'(screen_sel), 32'd0);
    check("rst_rgb",      32'(rgb),        32'h00);
    check("rst_game_en",  32'(game_en),    32'd0);
    check("rst_game_rst", 32'(game_rst),   32'd0);
    check("rst_frame",    32'(frame_cnt),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("title_state", 32'(screen_sel), 32'd0);
    check("title_rgb",   32'(rgb),        32'hA5);
    check("title_en",    32'(game_en),    32'd0);

    // 2. Start press -> 8 black frames -> PLAY.
    frame(1'b1, 1'b0, 1'b0);
    check("blank0_state", 32'(screen_sel), 32'd1);
    check("blank0_frame", 32'(frame_cnt),  32'd0);
    for (int j = 1; j <= 7; j++) begin
      if (j <= 4) check("blank_rgb", 32'(rgb), 32'h00);
      frame(1'b0, 1'b0, 1'b0);
      check("blank_state", 32'(screen_sel), 32'd1);
      check("blank_frame", 32'(frame_cnt),  32'(j));
      check("blank_en",    32'(game_en),    32'd0);
    end
    frame(1'b0, 1'b0, 1'b0);
    check("play_state",   32'(screen_sel), 32'd2);
    check("play_rst_cnt", 32'(rst_hi_cnt), 32'd1);
    check("play_en",      32'(game_en),    32'd1);
    check("play_frame",   32'(frame_cnt),  32'd0);
    check("play_rgb",     32'(rgb),        32'h3C);
    @(negedge clk);
    play_rgb = 8'h7E;
    #1;
    check("play_rgb_old", 32'(rgb), 32'h3C);
    @(negedge clk);
    #1;
    check("play_rgb_new", 32'(rgb), 32'h7E);

    // 3. Dead and done together -> LOSE wins.
    frame(1'b0, 1'b1, 1'b1);
    check("pl_blank_state", 32'(screen_sel), 32'd1);
    check("pl_blank_en",    32'(game_en),    32'd0);
    frames(8);
    check("lose_state",   32'(screen_sel), 32'd3);
    check("lose_rgb",     32'(rgb),        32'hC3);
    check("lose_rst_cnt", 32'(rst_hi_cnt), 32'd0);
    check("lose_en",      32'(game_en),    32'd0);

    // 4. Early press ignored, press at frame_cnt=60 accepted.
    frames(10);
    check("lose_frame10", 32'(frame_cnt), 32'd10);
    frame(1'b1, 1'b0, 1'b0);
    check("early_state", 32'(screen_sel), 32'd3);
    check("early_frame", 32'(frame_cnt),  32'd11);
    frames(49);
    check("lose_frame60", 32'(frame_cnt), 32'd60);
    frame(1'b1, 1'b0, 1'b0);
    check("hold_blank", 32'(screen_sel), 32'd1);
    check("hold_frame", 32'(frame_cnt),  32'd0);
    frames(8);
    check("back_title",     32'(screen_sel), 32'd0);
    check("back_title_rgb", 32'(rgb),        32'hA5);

    // 5. WIN timeout (default) versus no timeout.
    frame(1'b1, 1'b0, 1'b0);
    frames(8);
    check("play2_state", 32'(screen_sel), 32'd2);
    frame(1'b0, 1'b0, 1'b1);
    check("win_blank", 32'(screen_sel), 32'd1);
    frames(8);
    check("win_state",    32'(screen_sel),    32'd4);
    check("win_rgb",      32'(rgb),           32'h5A);
    check("win_state_nt", 32'(screen_sel_nt), 32'd4);
    frames(255);
    check("win_frame255",    32'(frame_cnt),    32'd255);
    check("win_state255",    32'(screen_sel),   32'd4);
    check("win_frame255_nt", 32'(frame_cnt_nt), 32'd255);
    frame(1'b0, 1'b0, 1'b0);
    check("timeout_blank", 32'(screen_sel),    32'd1);
    check("timeout_frame", 32'(frame_cnt),     32'd0);
    check("nt_stay_win",   32'(screen_sel_nt), 32'd4);
    check("nt_saturate",   32'(frame_cnt_nt),  32'd255);
    frames(8);
    check("timeout_title", 32'(screen_sel),    32'd0);
    check("nt_still_win",  32'(screen_sel_nt), 32'd4);

    // 6. Reset during BLANK frame 3, then a press before the first tick.
    frame(1'b1, 1'b0, 1'b0);
    frames(3);
    check("pre_rst_frame", 32'(frame_cnt), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(screen_sel), 32'd0);
    check("mid_rst_rgb",   32'(rgb),        32'h00);
    check("mid_rst_en",    32'(game_en),    32'd0);
    check("mid_rst_frame", 32'(frame_cnt),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame(1'b1, 1'b0, 1'b0);
    check("post_rst_blank", 32'(screen_sel), 32'd1);
    check("post_rst_frame", 32'(frame_cnt),  32'd0);
    frames(8);
    check("post_rst_play",  32'(screen_sel), 32'd2);
    check("post_rst_en",    32'(game_en),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
